// File: rtl/cnn_mul_parallel.sv
// -----------------------------------------------------------------------------
// cnn_mul_parallel
//
// Fully parallel 2-channel 3x3 convolution over a fixed 5x5 signed image.
// The image and both kernels are elaboration-time parameters. Valid padding
// and stride 1 give two 3x3 feature maps. Every clock, all 162 products and
// 18 nine-term sums are recomputed.
//
// Pipeline:
//   stage 1 : registered 11-bit products (9b pixel x 2b weight)
//   stage 2 : 15-bit accumulation, saturated to 12 bits, registered outputs
// Latency is 2 clocks from the first rising edge with rst low.
//
// Parameters:
//   IMG  225 bits, pixel k (9b signed) at IMG[9k+8:9k], k = 5*row + col
//   W1   18 bits, weight k (2b signed) at W1[2k+1:2k], k = 3*row + col
//   W2   same packing as W1
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset (clears all registers)
//   OR1_0..OR1_8   12b signed feature map for W1, OR1_k is (i,j), k = 3i + j
//   OR2_0..OR2_8   12b signed feature map for W2, same indexing
// -----------------------------------------------------------------------------
module cnn_mul_parallel #(
    // Default image: pixel k = k - 12, listed from k = 24 down to k = 0.
    parameter logic [224:0] IMG = {9'h00C, 9'h00B, 9'h00A, 9'h009, 9'h008,
                                   9'h007, 9'h006, 9'h005, 9'h004, 9'h003,
                                   9'h002, 9'h001, 9'h000, 9'h1FF, 9'h1FE,
                                   9'h1FD, 9'h1FC, 9'h1FB, 9'h1FA, 9'h1F9,
                                   9'h1F8, 9'h1F7, 9'h1F6, 9'h1F5, 9'h1F4},
    // Default W1: columns +1, 0, -1 on every row (weight 8 first).
    parameter logic [17:0]  W1  = 18'b11_00_01_11_00_01_11_00_01,
    // Default W2: identity kernel (center +1).
    parameter logic [17:0]  W2  = 18'b00_00_00_00_01_00_00_00_00
) (
    input  logic               clk,
    input  logic               rst,
    output logic signed [11:0] OR1_0,
    output logic signed [11:0] OR1_1,
    output logic signed [11:0] OR1_2,
    output logic signed [11:0] OR1_3,
    output logic signed [11:0] OR1_4,
    output logic signed [11:0] OR1_5,
    output logic signed [11:0] OR1_6,
    output logic signed [11:0] OR1_7,
    output logic signed [11:0] OR1_8,
    output logic signed [11:0] OR2_0,
    output logic signed [11:0] OR2_1,
    output logic signed [11:0] OR2_2,
    output logic signed [11:0] OR2_3,
    output logic signed [11:0] OR2_4,
    output logic signed [11:0] OR2_5,
    output logic signed [11:0] OR2_6,
    output logic signed [11:0] OR2_7,
    output logic signed [11:0] OR2_8
);

    localparam int NPOS = 9;  // output positions per map
    localparam int NTAP = 9;  // kernel taps per position

    typedef logic signed [10:0] prod_t;
    typedef logic signed [14:0] acc_t;
    typedef logic signed [11:0] out_t;

    localparam acc_t SAT_MAX = 15'sd2047;
    localparam acc_t SAT_MIN = -15'sd2048;

    // Pixel k of the image, raster order.
    function automatic logic signed [8:0] pixel(input int k);
        return $signed(IMG[9*k +: 9]);
    endfunction

    // Weight k of a packed 3x3 kernel.
    function automatic logic signed [1:0] weight(input logic [17:0] w, input int k);
        return $signed(w[2*k +: 2]);
    endfunction

    // Image index seen by tap t of output position p: row i+m, column j+n.
    function automatic int win_idx(input int p, input int t);
        return (p / 3 + t / 3) * 5 + (p % 3 + t % 3);
    endfunction

    // Both operands are sign-extended to 11 bits first; |product| <= 512.
    function automatic prod_t mul(input logic signed [8:0] a, input logic signed [1:0] b);
        prod_t ax;
        prod_t bx;
        ax = prod_t'(a);
        bx = prod_t'(b);
        return ax * bx;
    endfunction

    function automatic out_t sat12(input acc_t s);
        if (s > SAT_MAX)
            return 12'sd2047;
        else if (s < SAT_MIN)
            return -12'sd2048;
        else
            return out_t'(s);
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: products
    // ------------------------------------------------------------------
    prod_t prod1_q [NPOS][NTAP];
    prod_t prod2_q [NPOS][NTAP];

    // NOTE: these arrays are plain flip-flops, not a RAM, so they take the
    // asynchronous reset like any other register; a RAM macro could not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPOS; p++) begin
                for (int t = 0; t < NTAP; t++) begin
                    prod1_q[p][t] <= '0;
                    prod2_q[p][t] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NPOS; p++) begin
                for (int t = 0; t < NTAP; t++) begin
                    prod1_q[p][t] <= mul(pixel(win_idx(p, t)), weight(W1, t));
                    prod2_q[p][t] <= mul(pixel(win_idx(p, t)), weight(W2, t));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: nine-term sums (15 bits cannot overflow: 9 * 512 = 4608)
    // ------------------------------------------------------------------
    acc_t sum1 [NPOS];
    acc_t sum2 [NPOS];

    // NOTE: combinational accumulation uses blocking '=' so each partial sum
    // is visible to the next line; every element is zeroed first, which also
    // keeps the block free of latches.
    always_comb begin
        for (int p = 0; p < NPOS; p++) begin
            sum1[p] = '0;
            sum2[p] = '0;
            for (int t = 0; t < NTAP; t++) begin
                sum1[p] = sum1[p] + acc_t'(prod1_q[p][t]);
                sum2[p] = sum2[p] + acc_t'(prod2_q[p][t]);
            end
        end
    end

    out_t or1_q [NPOS];
    out_t or2_q [NPOS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPOS; p++) begin
                or1_q[p] <= '0;
                or2_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPOS; p++) begin
                or1_q[p] <= sat12(sum1[p]);
                or2_q[p] <= sat12(sum2[p]);
            end
        end
    end

    assign OR1_0 = or1_q[0];
    assign OR1_1 = or1_q[1];
    assign OR1_2 = or1_q[2];
    assign OR1_3 = or1_q[3];
    assign OR1_4 = or1_q[4];
    assign OR1_5 = or1_q[5];
    assign OR1_6 = or1_q[6];
    assign OR1_7 = or1_q[7];
    assign OR1_8 = or1_q[8];
    assign OR2_0 = or2_q[0];
    assign OR2_1 = or2_q[1];
    assign OR2_2 = or2_q[2];
    assign OR2_3 = or2_q[3];
    assign OR2_4 = or2_q[4];
    assign OR2_5 = or2_q[5];
    assign OR2_6 = or2_q[6];
    assign OR2_7 = or2_q[7];
    assign OR2_8 = or2_q[8];

endmodule

// File: tb/tb_cnn_mul_parallel.sv
// -----------------------------------------------------------------------------
// tb_cnn_mul_parallel
//
// Four instances of cnn_mul_parallel share clk/rst:
//   0: default parameters
//   1: image all -256, W1 all -2, W2 all +1        (both saturation limits)
//   2: alternating 255/-256 image, W1 center -2    (non-saturating mix)
//   3: pseudo-random image and kernels             (general arithmetic)
// A behavioural model computes every map directly from the convolution
// formula; a table holds hand-derived values for instances 0..2.
// -----------------------------------------------------------------------------
module tb_cnn_mul_parallel;

    localparam int NDUT = 4;

    // ---------------- parameter builders ----------------
    function automatic logic [224:0] img_ramp();
        logic [224:0] img;
        img = '0;
        for (int k = 0; k < 25; k++) img[9*k +: 9] = 9'(k - 12);
        return img;
    endfunction

    function automatic logic [224:0] img_fill(input int v);
        logic [224:0] img;
        img = '0;
        for (int k = 0; k < 25; k++) img[9*k +: 9] = 9'(v);
        return img;
    endfunction

    function automatic logic [224:0] img_alt();
        logic [224:0] img;
        img = '0;
        for (int k = 0; k < 25; k++) img[9*k +: 9] = (k % 2 == 1) ? 9'(255) : 9'(-256);
        return img;
    endfunction

    function automatic logic [224:0] img_rand(input logic [31:0] seed);
        logic [224:0] img;
        logic [31:0]  s;
        img = '0;
        s   = seed;
        for (int k = 0; k < 25; k++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            img[9*k +: 9] = s[8:0];
        end
        return img;
    endfunction

    function automatic logic [17:0] w_fill(input int v);
        logic [17:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[2*k +: 2] = 2'(v);
        return w;
    endfunction

    function automatic logic [17:0] w_center(input int v);
        logic [17:0] w;
        w = '0;
        w[9:8] = 2'(v);
        return w;
    endfunction

    // +1, 0, -1 across the columns of every row.
    function automatic logic [17:0] w_cols();
        logic [17:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[2*k +: 2] = 2'(1 - (k % 3));
        return w;
    endfunction

    function automatic logic [17:0] w_rand(input logic [31:0] seed);
        logic [17:0] w;
        logic [31:0] s;
        w = '0;
        s = seed;
        for (int k = 0; k < 9; k++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            w[2*k +: 2] = s[1:0];
        end
        return w;
    endfunction

    localparam logic [224:0] IMGS [NDUT] = '{img_ramp(), img_fill(-256), img_alt(),
                                             img_rand(32'h1234_5678)};
    localparam logic [17:0]  W1S  [NDUT] = '{w_cols(), w_fill(-2), w_center(-2),
                                             w_rand(32'h9e37_79b9)};
    localparam logic [17:0]  W2S  [NDUT] = '{w_center(1), w_fill(1), w_center(1),
                                             w_rand(32'h0bad_f00d)};

    // ---------------- reference model ----------------
    function automatic int ref_out(input logic [224:0] img, input logic [17:0] w, input int pos);
        int i;
        int j;
        int s;
        i = pos / 3;
        j = pos % 3;
        s = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                s += int'($signed(img[9*((i + m)*5 + (j + n)) +: 9]))
                   * int'($signed(w[2*(3*m + n) +: 2]));
        if (s > 2047)  return 2047;
        if (s < -2048) return -2048;
        return s;
    endfunction

    // ---------------- DUTs ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;

    wire signed [11:0] o1 [NDUT][9];
    wire signed [11:0] o2 [NDUT][9];

    always #5 clk = ~clk;

    cnn_mul_parallel u_def (
        .clk(clk), .rst(rst),
        .OR1_0(o1[0][0]), .OR1_1(o1[0][1]), .OR1_2(o1[0][2]),
        .OR1_3(o1[0][3]), .OR1_4(o1[0][4]), .OR1_5(o1[0][5]),
        .OR1_6(o1[0][6]), .OR1_7(o1[0][7]), .OR1_8(o1[0][8]),
        .OR2_0(o2[0][0]), .OR2_1(o2[0][1]), .OR2_2(o2[0][2]),
        .OR2_3(o2[0][3]), .OR2_4(o2[0][4]), .OR2_5(o2[0][5]),
        .OR2_6(o2[0][6]), .OR2_7(o2[0][7]), .OR2_8(o2[0][8])
    );

    for (genvar g = 1; g < NDUT; g++) begin : g_dut
        cnn_mul_parallel #(.IMG(IMGS[g]), .W1(W1S[g]), .W2(W2S[g])) u_dut (
            .clk(clk), .rst(rst),
            .OR1_0(o1[g][0]), .OR1_1(o1[g][1]), .OR1_2(o1[g][2]),
            .OR1_3(o1[g][3]), .OR1_4(o1[g][4]), .OR1_5(o1[g][5]),
            .OR1_6(o1[g][6]), .OR1_7(o1[g][7]), .OR1_8(o1[g][8]),
            .OR2_0(o2[g][0]), .OR2_1(o2[g][1]), .OR2_2(o2[g][2]),
            .OR2_3(o2[g][3]), .OR2_4(o2[g][4]), .OR2_5(o2[g][5]),
            .OR2_6(o2[g][6]), .OR2_7(o2[g][7]), .OR2_8(o2[g][8])
        );
    end

    // ---------------- checking ----------------
    typedef struct {
        string name;
        int    dut;
        int    map;
        int    pos;
        int    exp;
    } vec_t;

    vec_t vecs [$];
    int   def2 [9] = '{-6, -5, -4, -1, 0, 1, 4, 5, 6};
    int   exp1 [NDUT][9];
    int   exp2 [NDUT][9];
    int   n_checks = 0;
    int   n_errors = 0;
    int   live_edges = 0;  // rising edges seen with rst low since last reset

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Outputs are zero in reset and for the first live edge, final afterwards.
    task automatic check_all(input string tag);
        int e1;
        int e2;
        for (int g = 0; g < NDUT; g++) begin
            for (int p = 0; p < 9; p++) begin
                e1 = (!rst && live_edges >= 2) ? exp1[g][p] : 0;
                e2 = (!rst && live_edges >= 2) ? exp2[g][p] : 0;
                check($sformatf("%s dut%0d OR1_%0d", tag, g, p), int'(o1[g][p]), e1);
                check($sformatf("%s dut%0d OR2_%0d", tag, g, p), int'(o2[g][p]), e2);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) live_edges++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < NDUT; g++)
            for (int p = 0; p < 9; p++) begin
                exp1[g][p] = ref_out(IMGS[g], W1S[g], p);
                exp2[g][p] = ref_out(IMGS[g], W2S[g], p);
            end

        for (int p = 0; p < 9; p++) begin
            vecs.push_back('{$sformatf("def_or1_%0d", p), 0, 1, p, -6});
            vecs.push_back('{$sformatf("def_or2_%0d", p), 0, 2, p, def2[p]});
            vecs.push_back('{$sformatf("sat_pos_or1_%0d", p), 1, 1, p, 2047});
            vecs.push_back('{$sformatf("sat_neg_or2_%0d", p), 1, 2, p, -2048});
            vecs.push_back('{$sformatf("mix_or1_%0d", p), 2, 1, p, (p % 2 == 0) ? 512 : -510});
        end

        // Reset held for three cycles: everything reads zero.
        #1 rst = 1'b1;
        #1 check_all("reset_t0");
        repeat (3) begin
            tick();
            check_all("reset_hold");
        end

        // Release away from the clock edge.
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all("release_edge1");
        tick();
        check_all("release_edge2");
        tick();
        check_all("release_edge3");

        foreach (vecs[i]) begin
            check(vecs[i].name,
                  (vecs[i].map == 1) ? int'(o1[vecs[i].dut][vecs[i].pos])
                                     : int'(o2[vecs[i].dut][vecs[i].pos]),
                  vecs[i].exp);
        end

        // Randomly timed asynchronous resets mid-operation.
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            live_edges++;
            #($urandom_range(1, 7));
            rst = 1'b1;
            live_edges = 0;
            #1 check_all("mid_reset");
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_all("mid_reset_hold");
            end
            @(negedge clk);
            #($urandom_range(0, 3));
            rst = 1'b0;
            tick();
            check_all("recover_edge1");
            tick();
            check_all("recover_edge2");
        end

        // Long stability window.
        repeat (100) begin
            tick();
            check_all("stable");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
